// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS retirement trace path.
package mips_trace_pkg;

    // Records carry a full-width seq field; the top uses its low SEQ_W bits.
    localparam int SEQ_MAX_W = 32;

    localparam logic [31:0] SYSCALL_INSTR = 32'h0000000c;
    localparam logic [31:0] EXIT_CODE     = 32'd10;
    localparam logic [4:0]  REG_V0        = 5'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } shadow_t;

    typedef struct packed {
        logic [SEQ_MAX_W-1:0] seq;
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic                 wr_en;
        logic [4:0]           wr_addr;
        logic [31:0]          wr_data;
    } trace_rec_t;

endpackage

// File: rtl/retire_trace_gen_if.sv
// Trace output port of retire_trace_gen, grouped for the producer/consumer pair.
interface retire_trace_gen_if #(
    parameter int SEQ_W = 16
) ();
    // A record transfers on any edge where trace_valid & trace_ready are both 1.
    // While trace_valid is 1 and trace_ready is 0, every trace_* field holds steady.
    logic             trace_valid;
    logic             trace_ready;
    logic [SEQ_W-1:0] trace_seq;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic             trace_wr_en;
    logic [4:0]       trace_wr_addr;
    logic [31:0]      trace_wr_data;

    modport master (
        output trace_valid, trace_seq, trace_pc, trace_instr,
               trace_wr_en, trace_wr_addr, trace_wr_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_seq, trace_pc, trace_instr,
               trace_wr_en, trace_wr_addr, trace_wr_data,
        output trace_ready
    );
endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO; head reads zero whenever the FIFO is empty.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output trace_rec_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_rec_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_gen.sv
// Shadows pc/instr alongside the core pipeline and emits one commit record per retire.
module retire_trace_gen
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [31:0]       iss_pc,
    input  logic [31:0]       iss_instr,
    input  logic              stall,
    input  logic              flush,
    input  logic              instr_retired,
    input  logic              reg_wr_wb_ret,
    input  logic [4:0]        wr_addr_wb_ret,
    input  logic [31:0]       wr_data_wb_ret,
    retire_trace_gen_if.master trace,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              sync_err,
    output logic              done,
    input  logic              clear_err
);
    shadow_t          ex_q, mem_q, wb_q;
    logic [SEQ_W-1:0] seq_q;
    logic [31:0]      v0_q;
    trace_rec_t       rec;
    trace_rec_t       head;
    logic             full;
    logic             empty;
    logic             retire;
    logic             pop;
    logic             drop;
    logic             unused_seq_bits;

    assign retire = instr_retired & wb_q.valid;
    assign pop    = ~empty & trace.trace_ready;
    assign drop   = retire & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!stall) begin
            ex_q  <= '{valid: iss_valid & ~flush, pc: iss_pc, instr: iss_instr};
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Non-writing instructions carry zero addr/data so the trace is canonical.
    always_comb begin
        rec               = '0;
        rec.seq[SEQ_W-1:0] = seq_q;
        rec.pc            = wb_q.pc;
        rec.instr         = wb_q.instr;
        rec.wr_en         = reg_wr_wb_ret;
        rec.wr_addr       = reg_wr_wb_ret ? wr_addr_wb_ret : 5'd0;
        rec.wr_data       = reg_wr_wb_ret ? wr_data_wb_ret : 32'd0;
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (retire),
        .push_rec (rec),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // seq advances on dropped records too, leaving a visible gap downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q <= '0;
            v0_q  <= '0;
            done  <= 1'b0;
        end else if (retire) begin
            seq_q <= seq_q + 1'b1;
            if (reg_wr_wb_ret && (wr_addr_wb_ret == REG_V0)) v0_q <= wr_data_wb_ret;
            if ((wb_q.instr == SYSCALL_INSTR) && (v0_q == EXIT_CODE)) done <= 1'b1;
        end
    end

    // A new error in the same cycle as clear_err takes priority over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (clear_err)       drop_cnt <= DROP_W'(1);
                else if (~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
            if (instr_retired && !wb_q.valid) sync_err <= 1'b1;
            else if (clear_err)               sync_err <= 1'b0;
        end
    end

    assign trace.trace_valid   = ~empty;
    assign trace.trace_seq     = head.seq[SEQ_W-1:0];
    assign trace.trace_pc      = head.pc;
    assign trace.trace_instr   = head.instr;
    assign trace.trace_wr_en   = head.wr_en;
    assign trace.trace_wr_addr = head.wr_addr;
    assign trace.trace_wr_data = head.wr_data;
    assign unused_seq_bits     = ^head.seq;

endmodule

// File: doc/retire_trace_gen.md
Name: retire_trace_gen

Overview:
- Core-side producer of the instruction-retirement trace stream for the MIPS pipeline.
- Shadows pc/instr from issue through ex, mem and wb in lock-step with the core.
- At retire, merges each shadow entry with the register-file write-back and pushes a commit record into a small FIFO, drained over a valid/ready trace port.
- Flags end-of-program (syscall 0xc with $v0 == 10) and trace-integrity errors.

Parameters:
- DEPTH, 8, trace FIFO entries; power of two, minimum 2.
- SEQ_W, 16, width of retirement sequence number.
- DROP_W, 8, width of saturating dropped-record counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue stage holds a real instruction
- iss_pc  in  32  issue-stage pc
- iss_instr  in  32  issue-stage instruction
- stall  in  1  core pipeline hold; shadow pipe freezes
- flush  in  1  kill instruction moving issue->ex this cycle
- instr_retired  in  1  core retires the wb instruction this cycle
- reg_wr_wb_ret  in  1  retiring instruction writes register file
- wr_addr_wb_ret  in  5  destination register
- wr_data_wb_ret  in  32  write data
- trace_valid  out  1  record available
- trace_ready  in  1  consumer accepts record
- trace_seq  out  SEQ_W  record sequence number
- trace_pc  out  32  retired pc
- trace_instr  out  32  retired instruction
- trace_wr_en  out  1  register written
- trace_wr_addr  out  5  destination register
- trace_wr_data  out  32  written value
- overflow  out  1  sticky: record dropped on full FIFO
- drop_cnt  out  DROP_W  saturating count of dropped records
- sync_err  out  1  sticky: retire seen with invalid shadow wb entry
- done  out  1  sticky: end-of-program syscall retired
- clear_err  in  1  synchronous clear of overflow, drop_cnt, sync_err

Behaviour:
- Reset (reset low, async): all shadow valids 0, FIFO empty, trace_valid 0, all trace_* 0, seq 0, overflow 0, drop_cnt 0, sync_err 0, done 0, shadow $v0 0.
- Shadow pipe: three registered stages ex, mem, wb, each holding {valid, pc, instr}.
- Shadow pipe advances every cycle stall is 0; ex <= {iss_valid & ~flush, iss_pc, iss_instr}.
- stall 1: all stages hold. flush with stall: ignored (hold dominates).
- Latency: instruction in issue at cycle N with no stalls is in wb during N+3.
- Retire: instr_retired 1 and wb.valid 1 -> form record {seq, wb.pc, wb.instr, reg_wr_wb_ret, wr_addr, wr_data}.
  - Push record to FIFO; seq increments by 1 per pushed record, wraps modulo 2^SEQ_W.
  - wr_en 0: record wr_addr and wr_data forced to 0.
- Writes to $0 are recorded as presented (wr_en 1, addr 0); no filtering.
- instr_retired 1 with wb.valid 0: no push; sync_err set.
- Shadow $v0 update: updated when a retiring record has wr_en 1 and addr 2.
- done: set when a record with instr == 32'h0000000c is formed while shadow $v0 (value before this retire) == 10.
  - done is still set if the record is dropped. It stays set until reset.
- FIFO and trace port:
  - Output is first-word-fall-through from registered storage; a record pushed at edge E is visible (trace_valid 1) after E.
  - Pop on trace_valid & trace_ready.
  - trace_* stable while trace_valid 1 and trace_ready 0.
- Full-FIFO push:
  - Push with a simultaneous pop is accepted.
  - Push without a pop is dropped: seq still increments so the consumer sees the gap; overflow set; drop_cnt increments, saturating at all-ones.
- Empty-FIFO pop: trace_ready with trace_valid 0 is a no-op.
- clear_err: clears overflow, drop_cnt, sync_err next edge. A same-cycle new drop wins: overflow 1, drop_cnt 1.
- Pointers: log2(DEPTH)+1 bits; full/empty derived from the MSB difference.

Decomposition:
- Shared package mips_trace_pkg:
  - trace_rec_t struct {seq, pc, instr, wr_en, wr_addr, wr_data}.
  - Constants SYSCALL_INSTR = 32'h0000000c, EXIT_CODE = 10, REG_V0 = 2.
- Sub-module trace_fifo: parameterised by DEPTH, carrying trace_rec_t, with push/pop/full/empty.
- Shadow pipe, record formation and flags stay in the top.

Test Plan:
- Straight-line: 5 instructions at pc 0x0,0x4,..0x10, no stall, trace_ready 1 -> 5 records seq 0..4, each retired 3 cycles after issue, trace_valid one cycle after retire, pc order preserved.
- Stall/flush: stall 2 cycles mid-stream, flush on pc 0x8 -> pc 0x8 never traced; other pcs correct; retire on killed slot sets sync_err.
- Backpressure: DEPTH 8, trace_ready 0, 10 retires -> 8 records held, overflow 1, drop_cnt 2, seq of next accepted record is 10; then ready 1 drains seq 0..7 in order.
- Full with pop: FIFO full, push and pop same cycle -> no drop, count stays 8.
- End of program:
  - addiu $v0,$0,10 (wr addr 2 data 10) then syscall 0xc -> done 1 after syscall retire.
  - Syscall with $v0 = 4 -> done stays 0.
- Reset mid-stream: assert reset low with 3 records queued -> trace_valid 0, flags 0, seq restarts at 0 after release.
